// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional two-entry skid buffer and a saturating stall
// counter. Bubbles always present all-zero control so a stalled or flushed
// stage never asserts write enables downstream.
module pipe_stage_buf #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  Stall_Cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             out_valid;
    logic             in_ready;
    logic             accept;
    logic             drain;

    assign in_entry  = {In_Ctrl, In_Data};
    assign out_valid = (state_q != EMPTY);

    // With the skid buffer, In_Ready comes straight from a flop so there is
    // no combinational path from Out_Ready; without it, the single entry can
    // be replaced in the same cycle it drains.
    assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || Out_Ready);
    assign accept   = In_Valid && in_ready;
    assign drain    = out_valid && Out_Ready;

    assign In_Ready  = in_ready;
    assign Out_Valid = out_valid;
    assign Out_Ctrl  = out_valid ? main_q.ctrl : '0;
    assign Out_Data  = main_q.data;
    assign Occupancy = occ_q;
    assign Stall_Cnt = stall_cnt_q;

    // Next-state and storage update; Flush discards everything held and the
    // offer of the same cycle but leaves the main register contents intact.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept && (SKID != 0)) begin
                        // Entry arrived while downstream stalled: park it.
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Registered status derived from the next state.
    always_comb begin
        in_ready_d = (state_d != TWO);
        case (state_d)
            ONE:     occ_d = 2'd1;
            TWO:     occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // Saturating count of cycles where an entry is held back by downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !Out_Ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State and storage flops; reset clears everything including the counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: instance 0 uses the skid buffer,
// instance 1 is single-entry, instance 2 has a 4-bit stall counter.
module tb_pipe_stage_buf;

    logic         Clk = 1'b0;
    logic         rst;
    logic         flush     [3];
    logic         in_valid  [3];
    logic         out_ready [3];
    logic [11:0]  in_ctrl   [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [11:0]  out_ctrl  [3];
    logic [127:0] out_data  [3];
    logic [1:0]   occ       [3];
    logic [15:0]  stall_a, stall_b;
    logic [3:0]   stall_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    pipe_stage_buf #(.CTRL_W(12), .DATA_W(128), .SKID(1), .CNT_W(16)) u_skid (
        .Clk(Clk), .Rst(rst), .Flush(flush[0]), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
        .In_Ctrl(in_ctrl[0]), .In_Data(in_data[0]), .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]),
        .Out_Ctrl(out_ctrl[0]), .Out_Data(out_data[0]), .Occupancy(occ[0]), .Stall_Cnt(stall_a));

    pipe_stage_buf #(.CTRL_W(12), .DATA_W(128), .SKID(0), .CNT_W(16)) u_noskid (
        .Clk(Clk), .Rst(rst), .Flush(flush[1]), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
        .In_Ctrl(in_ctrl[1]), .In_Data(in_data[1]), .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]),
        .Out_Ctrl(out_ctrl[1]), .Out_Data(out_data[1]), .Occupancy(occ[1]), .Stall_Cnt(stall_b));

    pipe_stage_buf #(.CTRL_W(12), .DATA_W(128), .SKID(1), .CNT_W(4)) u_cnt4 (
        .Clk(Clk), .Rst(rst), .Flush(flush[2]), .In_Valid(in_valid[2]), .In_Ready(in_ready[2]),
        .In_Ctrl(in_ctrl[2]), .In_Data(in_data[2]), .Out_Valid(out_valid[2]), .Out_Ready(out_ready[2]),
        .Out_Ctrl(out_ctrl[2]), .Out_Data(out_data[2]), .Occupancy(occ[2]), .Stall_Cnt(stall_c));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (out_valid[d] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %0b want 0", d, out_valid[d]); end
            n_cmp++; if (out_ctrl[d] !== 12'h0) begin n_err++; $display("FAIL reset_ctrl[%0d]: got %0h want 0", d, out_ctrl[d]); end
            n_cmp++; if (out_data[d] !== 128'h0) begin n_err++; $display("FAIL reset_data[%0d]: got %0h want 0", d, out_data[d]); end
            n_cmp++; if (occ[d] !== 2'd0) begin n_err++; $display("FAIL reset_occ[%0d]: got %0d want 0", d, occ[d]); end
            n_cmp++; if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %0b want 1", d, in_ready[d]); end
        end
        n_cmp++; if (stall_a !== 16'd0) begin n_err++; $display("FAIL reset_stall_a: got %0d want 0", stall_a); end
        n_cmp++; if (stall_b !== 16'd0) begin n_err++; $display("FAIL reset_stall_b: got %0d want 0", stall_b); end
        n_cmp++; if (stall_c !== 4'd0) begin n_err++; $display("FAIL reset_stall_c: got %0d want 0", stall_c); end
    endtask

    task automatic test_fill();
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        in_valid[0] = 1'b1; in_ctrl[0] = 12'hFFF; in_data[0] = a5; out_ready[0] = 1'b1;
        #1;
        n_cmp++; if (out_ctrl[0] !== 12'h0) begin n_err++; $display("FAIL fill_pre_ctrl: got %0h want 0", out_ctrl[0]); end
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL fill_pre_valid: got %0b want 0", out_valid[0]); end
        tick();
        in_valid[0] = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL fill_valid: got %0b want 1", out_valid[0]); end
        n_cmp++; if (out_ctrl[0] !== 12'hFFF) begin n_err++; $display("FAIL fill_ctrl: got %0h want fff", out_ctrl[0]); end
        n_cmp++; if (out_data[0] !== a5) begin n_err++; $display("FAIL fill_data: got %0h want %0h", out_data[0], a5); end
        n_cmp++; if (occ[0] !== 2'd1) begin n_err++; $display("FAIL fill_occ: got %0d want 1", occ[0]); end
        tick();
        // Drained: bubble has zero control, data holds.
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL fill_drain_valid: got %0b want 0", out_valid[0]); end
        n_cmp++; if (out_ctrl[0] !== 12'h0) begin n_err++; $display("FAIL fill_bubble_ctrl: got %0h want 0", out_ctrl[0]); end
        n_cmp++; if (out_data[0] !== a5) begin n_err++; $display("FAIL fill_hold_data: got %0h want %0h", out_data[0], a5); end
    endtask

    task automatic test_stream();
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid[0] = 1'b1; in_ctrl[0] = 12'(i); in_data[0] = 128'(i);
            #1;
            n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready[0]); end
            tick();
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 128'(i) || out_ctrl[0] !== 12'(i)) begin
                n_err++; $display("FAIL stream_out[%0d]: got v=%0b d=%0h c=%0h want v=1 d=%0h c=%0h",
                                  i, out_valid[0], out_data[0], out_ctrl[0], i, i);
            end
        end
        in_valid[0] = 1'b0;
        tick();
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL stream_end_valid: got %0b want 0", out_valid[0]); end
    endtask

    // Out_Ready low in cycles 3..6; producer advances only on a handshake.
    task automatic test_skid();
        int exp_rdy [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        int exp_occ [11] = '{0, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1};
        int exp_out [11] = '{0, 1, 2, 3, 3, 3, 3, 3, 4, 5, 6};
        int  n = 1;
        logic acc;
        for (int c = 0; c <= 10; c++) begin
            out_ready[0] = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
            in_valid[0]  = (n <= 6);
            in_ctrl[0]   = 12'(n);
            in_data[0]   = 128'(n);
            #1;
            n_cmp++; if (in_ready[0] !== 1'(exp_rdy[c])) begin n_err++; $display("FAIL skid_in_ready[c%0d]: got %0b want %0d", c, in_ready[0], exp_rdy[c]); end
            n_cmp++; if (occ[0] !== 2'(exp_occ[c])) begin n_err++; $display("FAIL skid_occ[c%0d]: got %0d want %0d", c, occ[0], exp_occ[c]); end
            n_cmp++; if (out_valid[0] !== (exp_out[c] != 0)) begin n_err++; $display("FAIL skid_valid[c%0d]: got %0b want %0b", c, out_valid[0], exp_out[c] != 0); end
            if (exp_out[c] != 0) begin
                n_cmp++; if (out_data[0] !== 128'(exp_out[c])) begin n_err++; $display("FAIL skid_data[c%0d]: got %0h want %0h", c, out_data[0], exp_out[c]); end
            end
            acc = in_valid[0] & in_ready[0];
            tick();
            if (acc) n++;
        end
        in_valid[0] = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL skid_end_valid: got %0b want 0", out_valid[0]); end
        n_cmp++; if (stall_a !== 16'd4) begin n_err++; $display("FAIL skid_stall_cnt: got %0d want 4", stall_a); end
    endtask

    task automatic test_noskid();
        int exp_rdy [11] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        int exp_occ [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int exp_out [11] = '{0, 1, 2, 3, 3, 3, 3, 3, 4, 5, 6};
        int  n = 1;
        logic acc;
        for (int c = 0; c <= 10; c++) begin
            out_ready[1] = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
            in_valid[1]  = (n <= 6);
            in_ctrl[1]   = 12'(n);
            in_data[1]   = 128'(n);
            #1;
            n_cmp++; if (in_ready[1] !== 1'(exp_rdy[c])) begin n_err++; $display("FAIL noskid_in_ready[c%0d]: got %0b want %0d", c, in_ready[1], exp_rdy[c]); end
            if (out_valid[1] === 1'b1) begin
                n_cmp++; if (in_ready[1] !== out_ready[1]) begin n_err++; $display("FAIL noskid_ready_follow[c%0d]: got %0b want %0b", c, in_ready[1], out_ready[1]); end
            end
            n_cmp++; if (occ[1] !== 2'(exp_occ[c])) begin n_err++; $display("FAIL noskid_occ[c%0d]: got %0d want %0d", c, occ[1], exp_occ[c]); end
            n_cmp++; if (out_valid[1] !== (exp_out[c] != 0)) begin n_err++; $display("FAIL noskid_valid[c%0d]: got %0b want %0b", c, out_valid[1], exp_out[c] != 0); end
            if (exp_out[c] != 0) begin
                n_cmp++; if (out_data[1] !== 128'(exp_out[c])) begin n_err++; $display("FAIL noskid_data[c%0d]: got %0h want %0h", c, out_data[1], exp_out[c]); end
            end
            acc = in_valid[1] & in_ready[1];
            tick();
            if (acc) n++;
        end
        in_valid[1] = 1'b0;
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL noskid_end_valid: got %0b want 0", out_valid[1]); end
        n_cmp++; if (stall_b !== 16'd4) begin n_err++; $display("FAIL noskid_stall_cnt: got %0d want 4", stall_b); end
    endtask

    // Stall_Cnt enters at 4; stalls in the fill cycle and the flush cycle add 2.
    task automatic test_flush();
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_ctrl[0] = 12'h031; in_data[0] = 128'h31;
        tick();
        in_ctrl[0] = 12'h032; in_data[0] = 128'h32;
        tick();
        n_cmp++; if (occ[0] !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 2", occ[0]); end
        flush[0] = 1'b1; in_ctrl[0] = 12'h077; in_data[0] = 128'h77;
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        n_cmp++; if (occ[0] !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occ[0]); end
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid[0]); end
        n_cmp++; if (out_ctrl[0] !== 12'h0) begin n_err++; $display("FAIL flush_ctrl: got %0h want 0", out_ctrl[0]); end
        n_cmp++; if (out_data[0] !== 128'h31) begin n_err++; $display("FAIL flush_hold_data: got %0h want 31", out_data[0]); end
        n_cmp++; if (stall_a !== 16'd6) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want 6", stall_a); end
        // Flush while In_Ready=1: the offer must still be discarded.
        flush[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL flush_offer_ready: got %0b want 1", in_ready[0]); end
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL flush_discard_valid: got %0b want 0", out_valid[0]); end
        n_cmp++; if (occ[0] !== 2'd0) begin n_err++; $display("FAIL flush_discard_occ: got %0d want 0", occ[0]); end
        tick();
        n_cmp++; if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h31) begin
            n_err++; $display("FAIL flush_no_77: got v=%0b d=%0h want v=0 d=31", out_valid[0], out_data[0]);
        end
        n_cmp++; if (stall_a !== 16'd6) begin n_err++; $display("FAIL flush_stall_keep: got %0d want 6", stall_a); end
    endtask

    task automatic test_saturation();
        out_ready[2] = 1'b0;
        in_valid[2] = 1'b1; in_ctrl[2] = 12'h001; in_data[2] = 128'h55;
        tick();
        in_valid[2] = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        n_cmp++; if (stall_c !== 4'd14) begin n_err++; $display("FAIL sat_cnt14: got %0d want 14", stall_c); end
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if (stall_c !== 4'd15) begin n_err++; $display("FAIL sat_cnt15: got %0d want 15", stall_c); end
        n_cmp++; if (out_valid[2] !== 1'b1 || out_ctrl[2] !== 12'h001) begin
            n_err++; $display("FAIL sat_held: got v=%0b c=%0h want v=1 c=1", out_valid[2], out_ctrl[2]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (stall_c !== 4'd0) begin n_err++; $display("FAIL sat_rst_cnt: got %0d want 0", stall_c); end
        n_cmp++; if (out_valid[2] !== 1'b0) begin n_err++; $display("FAIL sat_rst_valid: got %0b want 0", out_valid[2]); end
        n_cmp++; if (out_data[2] !== 128'h0) begin n_err++; $display("FAIL sat_rst_data: got %0h want 0", out_data[2]); end
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL rst_in_ready[%0d]: got %0b want 1", d, in_ready[d]); end
        end
        n_cmp++; if (stall_a !== 16'd0) begin n_err++; $display("FAIL rst_stall_a: got %0d want 0", stall_a); end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            in_ctrl[d] = '0; in_data[d] = '0;
        end
        test_reset();
        test_fill();
        test_stream();
        test_skid();
        test_noskid();
        test_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional two-entry skid buffer. It is the generalised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): each stage instantiates it with its own packed control and data widths. It adds stall back-pressure, bubble insertion and stall accounting, which the fixed registers lack. Bubbles always present all-zero control, so a stalled or flushed stage never asserts RegWrite/MemWrite downstream.

## Interface
- CTRL_W, 12: width of packed control field (RegWrite, MemRead, MemWrite, ...); zeroed on bubbles.
- DATA_W, 128: width of packed datapath field (ALU result, store data, branch target, Rd, ...).
- SKID, 1: 1 = two-entry skid buffer, registered In_Ready; 0 = single entry, combinational In_Ready.
- CNT_W, 16: width of stall counter.

- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- Flush  in  1  discard all held entries this cycle (branch/jump redirect).
- In_Valid  in  1  upstream stage offers an entry.
- In_Ready  out  1  this block accepts an entry this cycle.
- In_Ctrl  in  CTRL_W  control field of offered entry.
- In_Data  in  DATA_W  data field of offered entry.
- Out_Valid  out  1  entry presented downstream.
- Out_Ready  in  1  downstream consumes the presented entry.
- Out_Ctrl  out  CTRL_W  control field; forced to 0 whenever Out_Valid=0.
- Out_Data  out  DATA_W  data field; holds last value when Out_Valid=0.
- Occupancy  out  2  number of held entries: 0, 1, 2.
- Stall_Cnt  out  CNT_W  saturating count of cycles with Out_Valid=1 and Out_Ready=0.

## Operation
- Storage: main register (drives outputs) and, if SKID=1, skid register. States: EMPTY, ONE, TWO (TWO only if SKID=1).
- Accept = In_Valid & In_Ready. Drain = Out_Valid & Out_Ready. Out_Valid = (state != EMPTY).
- In_Ready: SKID=1 -> (state != TWO), a register output with no combinational path from Out_Ready. SKID=0 -> !Out_Valid | Out_Ready.
- EMPTY: Accept -> ONE, main <= In.
- ONE: Accept & Drain -> ONE, main <= In. Accept & !Drain -> TWO, skid <= In (SKID=1 only). !Accept & Drain -> EMPTY. Neither -> hold.
- TWO: Drain -> ONE, main <= skid. No Accept possible. Otherwise hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by Flush.
- Flush has priority over everything: next state EMPTY; the entry offered that cycle is discarded even if In_Ready=1. Out_Data is not cleared. Upstream must not count a flushed offer as accepted.
- Out_Ctrl = Out_Valid ? main.ctrl : 0.
- Stall_Cnt increments when Out_Valid & !Out_Ready and saturates at 2^CNT_W-1. It is cleared only by Rst, not by Flush.
- Rst: state EMPTY, main and skid cleared to 0, Stall_Cnt 0.
- After Rst, outputs are: Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0, Stall_Cnt=0. In_Ready=1 in both modes.
- Rst has priority over Flush.

## Timing
- Latency: an entry accepted at edge N appears on Out_* after edge N (visible in cycle N+1) when the block was EMPTY or draining.
- Throughput: one entry per cycle sustained while Out_Ready=1, in both modes.
- SKID=1: when Out_Ready drops, In_Ready falls one cycle later. The entry accepted in the intervening cycle lands in the skid register.
- Flush asserted in cycle N: Out_Valid=0 and Out_Ctrl=0 from cycle N+1. A Drain in cycle N still completes, because downstream sampled the entry.
- Occupancy and Stall_Cnt are registered. Occupancy reflects the state after the last edge.

## Test plan
- Reset and fill: assert Rst 2 cycles, then offer ctrl=0xFFF, data=0xA5... with Out_Ready=1. Out_Valid=1 and Out_Ctrl=0xFFF next cycle; before that, Out_Ctrl=0.
- Streaming: 8 back-to-back entries 1..8, Out_Ready=1 throughout. Outputs 1..8 appear in consecutive cycles and In_Ready stays 1.
- Skid (SKID=1): stream entries and drop Out_Ready at entry 3 for 4 cycles. Occupancy goes 1->2 and In_Ready=0 after one cycle. Stall_Cnt=4. On release, 3,4,5... are output in order with none lost.
- No-skid (SKID=0): same stimulus. In_Ready equals Out_Ready in the same cycle, Occupancy never exceeds 1, and order is preserved.
- Flush: with Occupancy=2, assert Flush together with In_Valid=1 (data 0x77). Next cycle Occupancy=0, Out_Valid=0 and Out_Ctrl=0. Entry 0x77 never appears, and Stall_Cnt keeps its value.
- Saturation: with CNT_W=4, hold Out_Ready=0 for 20 cycles with Out_Valid=1. Stall_Cnt stops at 15, and Rst returns it to 0.
